// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response buffering,
// and branch redirect with draining of stale responses. Define FETCH_PERF_CNT_EN to add stall_cnt.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        branch_valid,
    input  logic [31:0] branch_target
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [31:0]       pc_r, pc_s;
    logic [CNT_W-1:0]  out_r, out_s;
    logic [CNT_W-1:0]  disc_r, disc_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic [PTR_W-1:0]  rd_ptr_r, rd_ptr_s;
    logic [PTR_W-1:0]  wr_ptr_r, wr_ptr_s;
    logic [31:0]       data_mem_r [FIFO_DEPTH];
    logic [31:0]       addr_mem_r [FIFO_DEPTH];
    logic              credit_s, accept_s, resp_s, push_s, pop_s;
    logic [31:0]       resp_addr_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return PTR_ZERO;
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    assign imem_addr   = pc_r;
    assign instr_valid = (count_r != CNT_ZERO);
    assign instr       = data_mem_r[rd_ptr_r];
    assign instr_pc    = addr_mem_r[rd_ptr_r];

    // Handshake decode and next-state computation for PC, counters, FIFO pointers and FSM
    always_comb begin
        credit_s = ({1'b0, out_r} + {1'b0, count_r}) < {1'b0, DEPTH_C};
        imem_req = (state_r == RUN) && !branch_valid && !reset && credit_s;
        accept_s = imem_req && imem_gnt;
        resp_s   = imem_rvalid && (out_r != CNT_ZERO);
        pop_s    = instr_valid && instr_ready;
        push_s   = resp_s && (disc_r == CNT_ZERO) && !branch_valid;
        // Responses only land in RUN with no stale traffic, so in-flight addresses are contiguous behind pc_r.
        resp_addr_s = pc_r - {{(30 - CNT_W){1'b0}}, out_r, 2'b00};

        state_s  = state_r;
        pc_s     = pc_r;
        out_s    = out_r;
        disc_s   = disc_r;
        count_s  = count_r;
        rd_ptr_s = rd_ptr_r;
        wr_ptr_s = wr_ptr_r;

        if (branch_valid) begin
            out_s    = out_r - CNT_W'(resp_s);
            disc_s   = out_s;
            count_s  = CNT_ZERO;
            rd_ptr_s = PTR_ZERO;
            wr_ptr_s = PTR_ZERO;
            pc_s     = branch_target & 32'hFFFF_FFFC;
            if (disc_s != CNT_ZERO) begin
                state_s = DRAIN;
            end else begin
                state_s = RUN;
            end
        end else begin
            if (accept_s) begin
                pc_s = pc_r + 32'd4;
            end else begin
                pc_s = pc_r;
            end
            out_s = out_r + CNT_W'(accept_s) - CNT_W'(resp_s);
            if (resp_s && (disc_r != CNT_ZERO)) begin
                disc_s = disc_r - CNT_ONE;
            end else begin
                disc_s = disc_r;
            end
            if (push_s) begin
                wr_ptr_s = ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            count_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            case (state_r)
                RUN: state_s = RUN;
                DRAIN: begin
                    if (disc_s == CNT_ZERO) begin
                        state_s = RUN;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: state_s = RUN;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= RUN;
            pc_r     <= RESET_PC;
            out_r    <= CNT_ZERO;
            disc_r   <= CNT_ZERO;
            count_r  <= CNT_ZERO;
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            out_r    <= out_s;
            disc_r   <= disc_s;
            count_r  <= count_s;
            rd_ptr_r <= rd_ptr_s;
            wr_ptr_r <= wr_ptr_s;
        end
    end

    // Instruction buffer storage; a write into the head slot while it is popped is safe
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= 32'h0000_0000;
                addr_mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            data_mem_r[wr_ptr_r] <= imem_rdata;
            addr_mem_r[wr_ptr_r] <= resp_addr_s;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating count of cycles with no instruction available
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'h0000_0000;
        end else if (!instr_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based model of the fetched instruction stream.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, branch_valid;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, branch_target;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .branch_valid(branch_valid), .branch_target(branch_target)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; int due; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic gnt; logic ready; logic req; logic [31:0] addr; logic valid; logic [31:0] pc; } vec_t;

    fl_t         infl[$];
    ent_t        mq[$];
    logic [31:0] mpc;
    int          cyc, lat_min, lat_max, acc_cnt;
    int          checks = 0;
    int          errors = 0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc, s_stall;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reset DUT and memory together; check reset-state outputs; release at a falling edge.
    task automatic do_reset();
        reset = 1'b1; imem_gnt = 1'b0; instr_ready = 1'b0; branch_valid = 1'b0;
        branch_target = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RPC);
        chk1("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        infl.delete(); mq.delete(); mpc = RPC; cyc = 0;
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs (memory answers in order), sample, check against the model.
    task automatic cycle_io(input logic g, input logic r, input logic b, input logic [31:0] t, input logic spur);
        fl_t  h;
        ent_t e;
        bit   resp, exp_req;
        int   nstale, lat;
        resp = 1'b0;
        if (spur) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_DEAD;
        end else if (infl.size() > 0 && infl[0].due <= cyc &&
                     (lat_min == lat_max || $urandom_range(3) != 0)) begin
            resp = 1'b1; imem_rvalid = 1'b1; imem_rdata = word(infl[0].addr);
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom;
        end
        imem_gnt = g; instr_ready = r; branch_valid = b; branch_target = t;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_instr = instr; s_pc = instr_pc;
`ifdef FETCH_PERF_CNT_EN
        s_stall = stall_cnt;
`else
        s_stall = 32'h0;
`endif
        nstale = 0;
        foreach (infl[i]) if (infl[i].stale) nstale++;
        exp_req = !b && (nstale == 0) && (infl.size() + mq.size() < DEPTH);
        chk1("imem_req", s_req, exp_req);
        if (s_req) chk("imem_addr", s_addr, mpc);
        chk1("instr_valid", s_valid, mq.size() != 0);
        if (s_valid && r && mq.size() > 0) begin
            e = mq.pop_front();
            chk("instr_pc", s_pc, e.pc);
            chk("instr", s_instr, e.data);
        end
        if (resp) begin
            h = infl.pop_front();
            if (!h.stale && !b) mq.push_back('{h.addr, word(h.addr)});
        end
        if (b) begin
            mq.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            mpc = t & 32'hFFFF_FFFC;
        end
        if (s_req && g) begin
            lat = $urandom_range(lat_max, lat_min);
            infl.push_back('{s_addr, 1'b0, cyc + lat});
            mpc = mpc + 32'd4;
            acc_cnt++;
        end
        @(negedge clk);
        cyc++;
    endtask

    vec_t tbl[9];
    bit   found;

    initial begin
        // gnt, ready | req, addr, valid, pc  (1-cycle memory from reset)
        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 32'h0C};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
        acc_cnt = 0; cyc = 0; s_stall = 32'h0;

        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle_io(tbl[i].gnt, tbl[i].ready, 1'b0, 32'h0, 1'b0);
            chk1("tbl_req", s_req, tbl[i].req);
            chk("tbl_addr", s_addr, tbl[i].addr);
            chk1("tbl_valid", s_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                chk("tbl_pc", s_pc, tbl[i].pc);
                chk("tbl_instr", s_instr, word(tbl[i].pc));
            end
        end

        // Controller stalled: credits cap requests, nothing lost on resume
        do_reset();
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) cycle_io(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_accepts", acc_cnt, DEPTH);
        chk1("stall_req_low", s_req, 1'b0);
        for (int i = 0; i < 8; i++) cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect with two requests in flight: drain both, restart at aligned target
        lat_min = 3; lat_max = 3;
        do_reset();
        cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle_io(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
        chk1("br_req", s_req, 1'b0);
        cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("drain_req0", s_req, 1'b0);
        cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("drain_req1", s_req, 1'b0);
        cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("resume_req", s_req, 1'b1);
        chk("resume_addr", s_addr, 32'h0000_0100);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle_io(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            if (s_valid) found = 1'b1;
        end
        chk1("br_seen", found, 1'b1);
        if (found) chk("br_first_pc", s_pc, 32'h0000_0100);

        // Redirect together with a response and a pop
        lat_min = 1; lat_max = 1;
        do_reset();
        cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle_io(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        chk1("brpop_valid", s_valid, 1'b1);
        chk("brpop_pc", s_pc, 32'h0);
        cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("brpop_flushed", s_valid, 1'b0);
        chk1("brpop_req", s_req, 1'b1);
        chk("brpop_addr", s_addr, 32'h0000_0200);

        // Grant withheld: address holds until accepted
        do_reset();
        cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle_io(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("nogrant_addr", s_addr, 32'h8);
        end
        cycle_io(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("grant_req", s_req, 1'b1);
        cycle_io(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("after_grant_addr", s_addr, 32'hC);

        // Response with nothing outstanding is ignored
        do_reset();
        cycle_io(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle_io(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("spur_valid", s_valid, 1'b0);
        chk1("spur_req", s_req, 1'b1);
        chk("spur_addr", s_addr, RPC);

`ifdef FETCH_PERF_CNT_EN
        lat_min = 2; lat_max = 2;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle_io(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            if (s_valid) found = 1'b1;
        end
        chk1("perf_seen", found, 1'b1);
        chk("stall_cnt", s_stall, 32'd3);
`endif

        // Randomized traffic with variable latency, redirects and occasional mid-flight resets
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 1000 == 999) do_reset();
            cycle_io($urandom_range(3) != 0, $urandom_range(9) < 7,
                     $urandom_range(19) == 0, $urandom, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
